morse_char_tx: RTL
==================

# morse_char_tx

Parametrised Morse transmitter for the full A–Z and 0–9 alphabet with correct ITU element spacing. It accepts one character code per ready/start handshake and drives a single keyed output, such as a board LED or buzzer, with dots, dashes, intra-character gaps and a trailing inter-character gap. It replaces the fixed A–H, half-second, switch-driven transmitter. An upstream text/UART feeder can stream characters back-to-back through the handshake.

## Interface
- `UNIT_CYCLES`, default 25_000_000: clock cycles per Morse time unit (0.5 s at 50 MHz); must be ≥ 2.
- `DASH_UNITS`, default 3: mark length of a dash, in units (a dot is always 1 unit).
- `GAP_UNITS`, default 3: space after the last element of a character, in units (the intra-character space is always 1 unit).
- `CLOCK_50  input  1`: the only clock; all logic on its rising edge.
- `rst  input  1`: asynchronous, active-high reset.
- `start  input  1`: request; accepted only in a cycle where `ready`=1.
- `char_code  input  6`: 0–25 = A–Z, 26–35 = digits 0–9, 36–63 invalid; sampled on accept.
- `ready  output  1`: idle and able to accept.
- `busy  output  1`: transmission in progress; always equal to ~`ready`.
- `key_out  output  1`: Morse keying, 1 = mark.
- `done  output  1`: one-cycle pulse in the final cycle of the inter-character gap.
- `err  output  1`: one-cycle pulse when a start with an invalid code is accepted.

## Operation
- Reset values: `key_out`=0, `ready`=1, `busy`=0, `done`=0, `err`=0, FSM=IDLE, all counters 0.
- FSM states:
  - IDLE: `ready`=1.
  - MARK: `key_out`=1.
  - SPACE: 1-unit intra-character gap.
  - GAP: `GAP_UNITS` inter-character gap.
- On accept, `char_code` is looked up in the ROM, giving a 5-bit pattern (bit0 transmitted first, 1 = dash) and a length of 1–5.
- The pattern and length are latched. Later changes on `char_code` have no effect until the next accept.
- Transitions:
  - IDLE + start + valid code → MARK.
  - IDLE + start + invalid code → IDLE; `err` pulses for one cycle; `key_out` stays 0.
  - MARK → SPACE when the element's units expire and elements remain; MARK → GAP when it was the last element.
  - SPACE → MARK for the next element.
  - GAP → IDLE on expiry, with `done` asserted in GAP's final cycle.
- Mark length: dot = `UNIT_CYCLES`; dash = `DASH_UNITS`×`UNIT_CYCLES`.
- Space lengths: intra-character space = `UNIT_CYCLES`; inter-character gap = `GAP_UNITS`×`UNIT_CYCLES`.
- `start` while busy is ignored, not queued. `start` held high re-accepts in the first cycle `ready` is 1 again, so streaming is back-to-back.
- Counters:
  - Cycle counter width is $clog2(`UNIT_CYCLES`); it wraps to 0 at `UNIT_CYCLES`-1 and produces a unit tick.
  - Unit counter width is $clog2(max(`DASH_UNITS`,`GAP_UNITS`)+1).
  - Element index is 3 bits.
  - All counters clear on every state entry.
- `rst` asserted at any time, including mid-mark, forces all reset values immediately, without waiting for a clock edge. A partial character is abandoned and is not resumed.

## Timing
- All outputs are registered, except `ready`/`busy`, which decode the state register.
- Let the accept edge be cycle 0:
  - `key_out` rises in cycle 1.
  - The first mark covers cycles 1..L.
  - Each following phase starts on the cycle after the previous phase ends.
- `ready` falls in cycle 1 and rises the cycle after `done`.
- Total busy cycles = `UNIT_CYCLES` × (sum of element units + (length−1) + `GAP_UNITS`).
- `err` pulses in cycle 1; `ready` stays 1 throughout an invalid-code accept.

## Structure
- Package `morse_pkg` holds:
  - the FSM state enum (IDLE, MARK, SPACE, GAP);
  - the code constants (CHAR_A=0, DIGIT_0=26, NUM_CODES=36);
  - the pattern/length field widths (5/3).
- Sub-module `morse_rom` is purely combinational: `char_code` → {`valid`, `pattern[4:0]`, `length[2:0]`}, with a 36-entry case table following ITU Morse.
- The top level contains the FSM, the cycle/unit counters and the latched pattern shift register.

## Test plan
All scenarios run with `UNIT_CYCLES`=4 and default units.
- 'E' (code 4) accepted at cycle 0 → `key_out`=1 in cycles 1–4, 0 in cycles 5–16; `done` in cycle 16; `ready`=1 in cycle 17.
- 'A' (code 0) → mark 1–4, space 5–8, mark 9–20, gap 21–32; `done` in cycle 32; exactly 2 rising edges on `key_out`.
- '0' (code 26, five dashes) → 88 busy cycles; 5 marks of 12 cycles each; `start` pulses during busy are ignored.
- Code 40 → `err` high in cycle 1 only; `key_out` stays 0; `ready` stays 1; a following 'T' (code 19) transmits normally.
- `rst` asserted in cycle 6 of a dash → `key_out`=0 and `ready`=1 immediately, without waiting for a clock edge. After release, 'E' transmits with the exact timing of the first scenario.
- `start` held high with `char_code`=19 → successive 'T' characters: 12 cycles mark then 12 cycles gap, repeating with no idle cycle beyond the single `ready` cycle.

Source files
------------

// File: rtl/morse_pkg.sv
// Shared types and constants for the Morse character transmitter.
// Code space: 0-25 letters A-Z, 26-35 digits 0-9, everything above is invalid.
package morse_pkg;

  typedef enum logic [1:0] {
    IDLE,
    MARK,
    SPACE,
    GAP
  } state_t;

  localparam int CHAR_A    = 0;
  localparam int DIGIT_0   = 26;
  localparam int NUM_CODES = 36;

  localparam int PAT_W = 5;
  localparam int LEN_W = 3;

endpackage

// File: rtl/morse_rom.sv
// Combinational ITU Morse lookup: pattern bit0 is sent first, 1 = dash.
// Each entry is {pattern, length}; a zero length marks an unused code.
module morse_rom
  import morse_pkg::*;
(
  input  logic [5:0]       char_code,
  output logic             valid,
  output logic [PAT_W-1:0] pattern,
  output logic [LEN_W-1:0] length
);

  logic [PAT_W+LEN_W-1:0] entry;

  always_comb begin
    entry = '0;
    case (char_code)
      6'd0:  entry = {5'b00010, 3'd2};
      6'd1:  entry = {5'b00001, 3'd4};
      6'd2:  entry = {5'b00101, 3'd4};
      6'd3:  entry = {5'b00001, 3'd3};
      6'd4:  entry = {5'b00000, 3'd1};
      6'd5:  entry = {5'b00100, 3'd4};
      6'd6:  entry = {5'b00011, 3'd3};
      6'd7:  entry = {5'b00000, 3'd4};
      6'd8:  entry = {5'b00000, 3'd2};
      6'd9:  entry = {5'b01110, 3'd4};
      6'd10: entry = {5'b00101, 3'd3};
      6'd11: entry = {5'b00010, 3'd4};
      6'd12: entry = {5'b00011, 3'd2};
      6'd13: entry = {5'b00001, 3'd2};
      6'd14: entry = {5'b00111, 3'd3};
      6'd15: entry = {5'b00110, 3'd4};
      6'd16: entry = {5'b01011, 3'd4};
      6'd17: entry = {5'b00010, 3'd3};
      6'd18: entry = {5'b00000, 3'd3};
      6'd19: entry = {5'b00001, 3'd1};
      6'd20: entry = {5'b00100, 3'd3};
      6'd21: entry = {5'b01000, 3'd4};
      6'd22: entry = {5'b00110, 3'd3};
      6'd23: entry = {5'b01001, 3'd4};
      6'd24: entry = {5'b01101, 3'd4};
      6'd25: entry = {5'b00011, 3'd4};
      // digits: 0..9 run from five dashes down to five dots and back up
      6'd26: entry = {5'b11111, 3'd5};
      6'd27: entry = {5'b11110, 3'd5};
      6'd28: entry = {5'b11100, 3'd5};
      6'd29: entry = {5'b11000, 3'd5};
      6'd30: entry = {5'b10000, 3'd5};
      6'd31: entry = {5'b00000, 3'd5};
      6'd32: entry = {5'b00001, 3'd5};
      6'd33: entry = {5'b00011, 3'd5};
      6'd34: entry = {5'b00111, 3'd5};
      6'd35: entry = {5'b01111, 3'd5};
      default: entry = '0;
    endcase
  end

  assign pattern = entry[PAT_W+LEN_W-1:LEN_W];
  assign length  = entry[LEN_W-1:0];
  assign valid   = (int'(char_code) < NUM_CODES);

endmodule

// File: rtl/morse_char_tx.sv
// Morse transmitter: one character per ready/start handshake, keyed on key_out
// with ITU element, intra-character and inter-character spacing.
module morse_char_tx
  import morse_pkg::*;
#(
  parameter int UNIT_CYCLES = 25_000_000,
  parameter int DASH_UNITS  = 3,
  parameter int GAP_UNITS   = 3
) (
  input  logic       CLOCK_50,
  input  logic       rst,
  input  logic       start,
  input  logic [5:0] char_code,
  output logic       ready,
  output logic       busy,
  output logic       key_out,
  output logic       done,
  output logic       err
);

  localparam int CYC_W     = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;
  localparam int MAX_UNITS = (DASH_UNITS > GAP_UNITS) ? DASH_UNITS : GAP_UNITS;
  localparam int UNIT_W    = (MAX_UNITS > 0) ? $clog2(MAX_UNITS + 1) : 1;

  state_t             state_reg;
  logic [CYC_W-1:0]   cyc_cnt_reg;
  logic [UNIT_W-1:0]  unit_cnt_reg;
  logic [2:0]         elem_reg;
  logic [PAT_W-1:0]   pat_reg;
  logic [LEN_W-1:0]   len_reg;
  logic               key_reg;
  logic               done_reg;
  logic               err_reg;

  logic               rom_valid;
  logic [PAT_W-1:0]   rom_pattern;
  logic [LEN_W-1:0]   rom_length;

  logic               unit_tick;
  logic               gap_last;
  logic [UNIT_W-1:0]  mark_last;

  morse_rom u_rom (
    .char_code (char_code),
    .valid     (rom_valid),
    .pattern   (rom_pattern),
    .length    (rom_length)
  );

  assign unit_tick = (cyc_cnt_reg == CYC_W'(UNIT_CYCLES - 1));
  assign gap_last  = (unit_cnt_reg == UNIT_W'(GAP_UNITS - 1));
  assign mark_last = pat_reg[0] ? UNIT_W'(DASH_UNITS - 1) : '0;

  // Every state change happens on a unit tick, so the cycle and unit counters
  // are naturally zero on entry; elem_reg indexes the character and only
  // clears on accept.
  always_ff @(posedge CLOCK_50 or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      cyc_cnt_reg  <= '0;
      unit_cnt_reg <= '0;
      elem_reg     <= '0;
      pat_reg      <= '0;
      len_reg      <= '0;
      key_reg      <= 1'b0;
      done_reg     <= 1'b0;
      err_reg      <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      err_reg  <= 1'b0;

      if (state_reg == IDLE || unit_tick)
        cyc_cnt_reg <= '0;
      else
        cyc_cnt_reg <= cyc_cnt_reg + CYC_W'(1);

      case (state_reg)
        IDLE: begin
          unit_cnt_reg <= '0;
          if (start) begin
            if (rom_valid) begin
              state_reg <= MARK;
              key_reg   <= 1'b1;
              pat_reg   <= rom_pattern;
              len_reg   <= rom_length;
              elem_reg  <= '0;
            end else begin
              err_reg <= 1'b1;
            end
          end
        end

        MARK: begin
          if (unit_tick) begin
            if (unit_cnt_reg == mark_last) begin
              unit_cnt_reg <= '0;
              key_reg      <= 1'b0;
              if (elem_reg == len_reg - 3'd1) begin
                state_reg <= GAP;
              end else begin
                state_reg <= SPACE;
                pat_reg   <= pat_reg >> 1;
                elem_reg  <= elem_reg + 3'd1;
              end
            end else begin
              unit_cnt_reg <= unit_cnt_reg + UNIT_W'(1);
            end
          end
        end

        SPACE: begin
          if (unit_tick) begin
            state_reg    <= MARK;
            key_reg      <= 1'b1;
            unit_cnt_reg <= '0;
          end
        end

        GAP: begin
          // registered, so raise it one cycle early to land in GAP's last cycle
          if (cyc_cnt_reg == CYC_W'(UNIT_CYCLES - 2) && gap_last)
            done_reg <= 1'b1;
          if (unit_tick) begin
            if (gap_last) begin
              state_reg    <= IDLE;
              unit_cnt_reg <= '0;
            end else begin
              unit_cnt_reg <= unit_cnt_reg + UNIT_W'(1);
            end
          end
        end

        default: state_reg <= IDLE;
      endcase
    end
  end

  assign ready   = (state_reg == IDLE);
  assign busy    = ~ready;
  assign key_out = key_reg;
  assign done    = done_reg;
  assign err     = err_reg;

endmodule
